// File: rtl/axi_regfile_gen_if.sv
// AXI4-Lite slave channel bundle for the generated register file.
// Signal names follow the AXI wire names so waveforms map one-to-one onto the bus.
interface axi_regfile_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_regfile_gen.sv
// Parameterised AXI4-Lite register file with read-only, self-clearing and strobe outputs.
// AW and W are captured independently; the write commits one edge after both are held.
module axi_regfile_gen #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = 'h3,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = 'h0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    axi_regfile_gen_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] slv_reg,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] slv_read,
    output logic [NUM_REGS-1:0]            wr_stb,
    output logic [NUM_REGS-1:0]            rd_stb
);
    localparam int              STRB_W      = DATA_WIDTH / 8;
    localparam int              ADDR_LSB    = $clog2(STRB_W);
    localparam int              IDX_W       = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0]  NUM_REGS_W  = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [NUM_REGS-1:0]   rd_stb_q, rd_stb_d;

    logic                  commit;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [IDX_W-1:0]      ar_idx;

    assign commit      = aw_held_q && w_held_q && !bvalid_q;
    assign aw_in_range = {1'b0, aw_idx_q} < NUM_REGS_W;
    assign ar_idx      = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_in_range = {1'b0, ar_idx} < NUM_REGS_W;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        wr_stb_d  = '0;
        rd_stb_d  = '0;
        // Self-clearing registers fall back to zero unless this edge writes them.
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i] = PULSE_MASK[i] ? '0 : reg_q[i];
        end

        if (s_axi.S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (s_axi.S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) begin
                    wr_stb_d[i] = 1'b1;
                    reg_d[i]    = reg_q[i];
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) reg_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        // Held address and data stay parked until the response is taken.
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;

        // Reads sample reg_q, so a same-edge commit is not visible yet.
        if (s_axi.S_AXI_ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rd_stb_d[i] = 1'b1;
                    rdata_d     = RO_MASK[i] ? slv_read[i*DATA_WIDTH +: DATA_WIDTH] : reg_q[i];
                end
            end
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
        end
    end

    always_comb begin
        slv_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) slv_reg[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign wr_stb              = wr_stb_q;
    assign rd_stb              = rd_stb_q;

    // Protection bits and sub-word address bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                             s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0],
                             slv_read};
endmodule

// File: tb/tb_axi_regfile_gen.sv
// Self-checking bench for axi_regfile_gen: directed AXI-Lite scenarios plus randomized
// reads/writes checked against an array-based model of the register file.
module tb_axi_regfile_gen;
    localparam int              NR      = 12;
    localparam int              VW      = NR * 32;
    localparam logic [NR-1:0]   RO_M    = 12'h003;
    localparam logic [NR-1:0]   PULSE_M = 12'h100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] slv_reg;
    logic [VW-1:0] slv_read;
    logic [NR-1:0] wr_stb;
    logic [NR-1:0] rd_stb;
    int            checks   = 0;
    int            failures = 0;
    logic [31:0]   model_reg [NR];
    logic [31:0]   got;

    axi_regfile_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus();

    axi_regfile_gen #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR),
        .RO_MASK(RO_M), .PULSE_MASK(PULSE_M)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus),
        .slv_reg(slv_reg), .slv_read(slv_read), .wr_stb(wr_stb), .rd_stb(rd_stb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] modelVec();
        logic [VW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model_reg[i];
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) model_reg[i] = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_awready"}, bus.S_AXI_AWREADY, 0);
        checkOutput({tag, "_wready"},  bus.S_AXI_WREADY, 0);
        checkOutput({tag, "_arready"}, bus.S_AXI_ARREADY, 0);
        checkOutput({tag, "_bvalid"},  bus.S_AXI_BVALID, 0);
        checkOutput({tag, "_rvalid"},  bus.S_AXI_RVALID, 0);
        checkOutput({tag, "_bresp"},   bus.S_AXI_BRESP, 0);
        checkOutput({tag, "_rresp"},   bus.S_AXI_RRESP, 0);
        checkOutput({tag, "_rdata"},   bus.S_AXI_RDATA, 0);
        checkOutput({tag, "_wr_stb"},  wr_stb, 0);
        checkOutput({tag, "_rd_stb"},  rd_stb, 0);
        checkOutput({tag, "_slv_reg"}, slv_reg, modelVec());
    endtask

    // AW is offered from cycle aw_start, W from cycle w_start; BREADY stays low 1+b_delay cycles after commit.
    task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start, input int b_delay);
        int            idx;
        int            cyc;
        bit            aw_done, w_done, aw_hs, w_hs;
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_stb;
        idx      = int'(addr[7:2]);
        exp_stb  = '0;
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        if (idx < NR && !RO_M[idx]) exp_stb[idx] = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_start) begin
                bus.S_AXI_AWADDR  = addr;
                bus.S_AXI_AWVALID = 1'b1;
            end
            if (!w_done && cyc >= w_start) begin
                bus.S_AXI_WDATA  = data;
                bus.S_AXI_WSTRB  = strb;
                bus.S_AXI_WVALID = 1'b1;
            end
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            tick();
            if (aw_hs) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
            cyc++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        checkOutput("aw_handshake", aw_done, 1);
        checkOutput("w_handshake", w_done, 1);
        checkOutput("bvalid_before_commit", bus.S_AXI_BVALID, 0);
        checkOutput("reg_before_commit", slv_reg, modelVec());

        if (exp_stb != '0) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model_reg[idx][8*b +: 8] = data[8*b +: 8];
        end
        tick();
        checkOutput("bvalid_at_commit", bus.S_AXI_BVALID, 1);
        checkOutput("bresp", bus.S_AXI_BRESP, exp_resp);
        checkOutput("wr_stb", wr_stb, exp_stb);
        checkOutput("reg_after_commit", slv_reg, modelVec());

        for (int i = 0; i < NR; i++) if (PULSE_M[i]) model_reg[i] = '0;
        for (int k = 0; k <= b_delay; k++) begin
            tick();
            checkOutput("wr_stb_single", wr_stb, 0);
            checkOutput("reg_hold", slv_reg, modelVec());
            checkOutput("bvalid_hold", bus.S_AXI_BVALID, 1);
            checkOutput("bresp_hold", bus.S_AXI_BRESP, exp_resp);
            checkOutput("awready_while_b", bus.S_AXI_AWREADY, 0);
            checkOutput("wready_while_b", bus.S_AXI_WREADY, 0);
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("bvalid_released", bus.S_AXI_BVALID, 0);
    endtask

    task automatic axiRead(input logic [7:0] addr, input int r_delay, output logic [31:0] rd);
        int            idx;
        int            waited;
        bit            done;
        logic [31:0]   exp_data;
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_stb;
        idx      = int'(addr[7:2]);
        exp_stb  = '0;
        exp_data = '0;
        exp_resp = 2'b10;
        if (idx < NR) begin
            exp_resp     = 2'b00;
            exp_stb[idx] = 1'b1;
            exp_data     = RO_M[idx] ? slv_read[idx*32 +: 32] : model_reg[idx];
        end
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        done = 0; waited = 0;
        while (!done && waited < 20) begin
            done = bus.S_AXI_ARREADY;
            tick();
            waited++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        checkOutput("ar_handshake", done, 1);
        checkOutput("rvalid", bus.S_AXI_RVALID, 1);
        checkOutput("rdata", bus.S_AXI_RDATA, exp_data);
        checkOutput("rresp", bus.S_AXI_RRESP, exp_resp);
        checkOutput("rd_stb", rd_stb, exp_stb);
        rd = bus.S_AXI_RDATA;
        for (int k = 0; k <= r_delay; k++) begin
            tick();
            checkOutput("rd_stb_single", rd_stb, 0);
            checkOutput("rvalid_hold", bus.S_AXI_RVALID, 1);
            checkOutput("rdata_hold", bus.S_AXI_RDATA, exp_data);
            checkOutput("rresp_hold", bus.S_AXI_RRESP, exp_resp);
            checkOutput("arready_while_r", bus.S_AXI_ARREADY, 0);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        checkOutput("rvalid_released", bus.S_AXI_RVALID, 0);
    endtask

    task automatic applyStimulus(input int n);
        logic [5:0]  ridx;
        logic [7:0]  addr;
        logic [31:0] rd;
        for (int t = 0; t < n; t++) begin
            ridx = 6'($urandom_range(0, 15));
            addr = {ridx, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                axiWrite(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                for (int i = 0; i < NR; i++) slv_read[i*32 +: 32] = $urandom;
                axiRead(addr, int'($urandom_range(0, 2)), rd);
            end
        end
    endtask

    // Reset lands after the AW handshake but before W; the later W alone must never commit.
    task automatic resetMidWrite();
        bus.S_AXI_AWADDR  = 8'h14;
        bus.S_AXI_AWVALID = 1'b1;
        checkOutput("mid_awready", bus.S_AXI_AWREADY, 1);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        bus.S_AXI_WDATA  = 32'hCAFEF00D;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        checkOutput("mid_wready", bus.S_AXI_WREADY, 1);
        tick();
        bus.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("mid_no_bvalid", bus.S_AXI_BVALID, 0);
            checkOutput("mid_no_wr_stb", wr_stb, 0);
            checkOutput("mid_no_commit", slv_reg, modelVec());
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.S_AXI_AWADDR  = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        slv_read = '0;
        rst_n    = 1'b0;
        modelReset();
        #2;
        checkResetOutputs("por");
        repeat (3) tick();
        rst_n = 1'b1;
        checkOutput("awready_at_release", bus.S_AXI_AWREADY, 0);
        tick();
        checkOutput("awready_after_release", bus.S_AXI_AWREADY, 1);
        checkOutput("wready_after_release", bus.S_AXI_WREADY, 1);
        checkOutput("arready_after_release", bus.S_AXI_ARREADY, 1);

        axiWrite(8'h1C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        checkOutput("reg7_value", slv_reg[7*32 +: 32], 32'hA5A5A5A5);
        axiWrite(8'h08, 32'h0BADF00D, 4'hF, 3, 0, 4);
        axiWrite(8'h0C, 32'h11223344, 4'hF, 0, 0, 0);
        axiWrite(8'h0C, 32'hFFFFFFFF, 4'h5, 0, 1, 1);
        checkOutput("byte_strobe", slv_reg[3*32 +: 32], 32'h11FF33FF);

        slv_read[31:0] = 32'hDEADBEEF;
        axiRead(8'h00, 1, got);
        checkOutput("ro_readback", got, 32'hDEADBEEF);
        axiWrite(8'h00, 32'h12345678, 4'hF, 1, 0, 0);
        checkOutput("ro_unchanged", slv_reg[31:0], 32'h0);

        axiWrite(8'h40, 32'h55AA55AA, 4'hF, 0, 0, 0);
        axiRead(8'h40, 0, got);
        checkOutput("oor_rdata", got, 32'h0);

        axiWrite(8'h20, 32'h00000001, 4'hF, 0, 0, 0);
        axiRead(8'h1C, 0, got);

        applyStimulus(60);
        resetMidWrite();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/axi_regfile_gen.md
AXI_REGFILE_GEN -- requirements
Module: axi_regfile_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, register and AXI data width; legal values 32 or 64.
- ADDR_WIDTH, 8, AXI byte-address width.
- NUM_REGS, 16, register count; legal range 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, 'h3, bit i=1 means register i is read-only and returns slv_read[i].
- PULSE_MASK, 'h0, bit i=1 means register i is self-clearing.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- S_AXI_ACLK, in, 1, the single clock.
- S_AXI_ARESETN, in, 1, asynchronous active-low reset.
- S_AXI_AWADDR, in, ADDR_WIDTH, write address.
- S_AXI_AWPROT, in, 3, ignored.
- S_AXI_AWVALID, in, 1, AXI write-address valid.
- S_AXI_AWREADY, out, 1, AXI write-address ready.
- S_AXI_WDATA, in, DATA_WIDTH, write data.
- S_AXI_WSTRB, in, DATA_WIDTH/8, byte enables.
- S_AXI_WVALID, in, 1, AXI write-data valid.
- S_AXI_WREADY, out, 1, AXI write-data ready.
- S_AXI_BRESP, out, 2, write response.
- S_AXI_BVALID, out, 1, AXI write-response valid.
- S_AXI_BREADY, in, 1, AXI write-response ready.
- S_AXI_ARADDR, in, ADDR_WIDTH, read address.
- S_AXI_ARPROT, in, 3, ignored.
- S_AXI_ARVALID, in, 1, AXI read-address valid.
- S_AXI_ARREADY, out, 1, AXI read-address ready.
- S_AXI_RDATA, out, DATA_WIDTH, read data.
- S_AXI_RRESP, out, 2, read response.
- S_AXI_RVALID, out, 1, AXI read-data valid.
- S_AXI_RREADY, in, 1, AXI read-data ready.
- slv_reg, out, NUM_REGS*DATA_WIDTH, register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- slv_read, in, NUM_REGS*DATA_WIDTH, readback values for the RO registers.
- wr_stb, out, NUM_REGS, one-cycle pulse when register i is written.
- rd_stb, out, NUM_REGS, one-cycle pulse when register i is read.

Function
REQ-003 The register index SHALL be ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; an index >= NUM_REGS is out of range.

REQ-004 The write channel SHALL accept AW and W independently.
- AWREADY=1 while no address is held and BVALID=0.
- WREADY=1 while no data is held and BVALID=0.
- Each handshake latches its payload; the two may complete in the same cycle or in either order.

REQ-005 Commit SHALL occur on the clock edge after the edge on which the second of AW/W is latched.
- On that edge: the register updates, wr_stb[i] pulses for one cycle, and BVALID rises.
- Write latency is therefore 1 cycle after the final handshake.

REQ-006 A commit SHALL update only the bytes whose WSTRB bit is 1; bytes with WSTRB=0 keep their previous value.

REQ-007 A write to an RO register SHALL leave it unchanged, assert no wr_stb, and return BRESP=OKAY (2'b00).

REQ-008 A write to an out-of-range index SHALL change nothing, assert no wr_stb, and return BRESP=SLVERR (2'b10).

REQ-009 BVALID SHALL hold, with BRESP stable, until BREADY=1.
- The held AW/W are released on the BVALID&BREADY edge.
- AWREADY/WREADY may reassert in the next cycle.

REQ-010 A PULSE_MASK register SHALL return to 0 one cycle after its commit.

REQ-011 The read channel SHALL hold one outstanding read.
- ARREADY=1 while RVALID=0.
- On the AR handshake edge, RDATA latches: slv_read[i] if RO_MASK[i]=1, else slv_reg[i]; out of range gives 0.
- On the same edge, RVALID rises and rd_stb[i] pulses for one cycle (no pulse if out of range).
- Read latency is 1 cycle.

REQ-012 RRESP SHALL be OKAY in range and SLVERR out of range; RDATA/RRESP hold stable until RVALID&RREADY.

REQ-013 A read and a commit to the same register on the same edge SHALL return the pre-write value.

REQ-014 A back-to-back transaction SHALL be accepted no earlier than the cycle after the previous response handshake.

Reset
REQ-015 When S_AXI_ARESETN=0, asynchronously, mid-transaction included:
- All registers clear to 0 and held AW/W state is discarded.
- AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_stb and rd_stb go to 0.
- BRESP, RRESP and RDATA go to 0.

REQ-016 Ready signals SHALL first assert in the cycle after reset deasserts.

Verification
REQ-017 The bench SHALL cover these directed scenarios (defaults, DATA_WIDTH=32):
- Write 0xA5A5A5A5 to addr 0x1C with WSTRB=0xF, AW/W in the same cycle -> slv_reg[7]=0xA5A5A5A5 one cycle later, wr_stb[7] pulses once, BRESP=00.
- W presented 3 cycles before AW to addr 0x08 -> commit exactly 1 cycle after the AW handshake; AWREADY/WREADY stay 0 while BVALID=1 and BREADY is held low for 4 cycles.
- slv_reg[3]=0x11223344, then write 0xFFFFFFFF with WSTRB=0x5 -> slv_reg[3]=0x11FF33FF.
- Read addr 0x00 with slv_read[0]=0xDEADBEEF -> RDATA=0xDEADBEEF, RRESP=00, rd_stb[0] pulses; a write to addr 0x00 -> no change, BRESP=00.
- NUM_REGS=12: write and read addr 0x40 -> BRESP=10, RRESP=10, RDATA=0, no strobes.
- PULSE_MASK='h100, write 1 to addr 0x20 -> slv_reg[8]=1 for exactly one cycle; ARESETN pulsed low between AW and W handshakes -> no commit, all outputs 0.
